// File: rtl/prefetcher_pkg.sv
// Shared types for the prefetcher traffic sources.
package prefetcher_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        ERR   = 2'd3
    } rdgen_state_e;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_LAST  = 2'd1,
        ERR_ID    = 2'd2,
        ERR_UNSOL = 2'd3
    } rdgen_err_e;

endpackage

// File: rtl/axi_stride_rd_gen.sv
// AXI4 read-only strided traffic master with R-channel protocol checking.
//
// state | meaning
// IDLE  | waiting for start, no traffic, R not accepted
// RUN   | issuing bursts at base + k*stride, collecting beats
// DRAIN | all bursts issued, waiting for the remaining last beats
// ERR   | protocol error latched; beats drained and discarded until start
module axi_stride_rd_gen
    import prefetcher_pkg::*;
#(
    parameter int ADDR_BITS            = 64,
    parameter int BURST_LEN_WIDTH      = 8,
    parameter int TID_WIDTH            = 4,
    parameter int LOG_BLOCK_DATA_BYTES = 3,
    parameter int LOG_MAX_OUTSTANDING  = 2,
    parameter int CNT_WIDTH            = 16
) (
    input  logic                                   clk,
    input  logic                                   resetN,
    input  logic                                   start,
    input  logic [ADDR_BITS-1:0]                   cfg_base,
    input  logic [ADDR_BITS-1:0]                   cfg_stride,
    input  logic [CNT_WIDTH-1:0]                   cfg_count,
    input  logic [BURST_LEN_WIDTH-1:0]             cfg_len,
    input  logic [TID_WIDTH-1:0]                   cfg_id,
    output logic                                   m_ar_valid,
    input  logic                                   m_ar_ready,
    output logic [ADDR_BITS-1:0]                   m_ar_addr,
    output logic [BURST_LEN_WIDTH-1:0]             m_ar_len,
    output logic [TID_WIDTH-1:0]                   m_ar_id,
    input  logic                                   m_r_valid,
    output logic                                   m_r_ready,
    input  logic                                   m_r_last,
    input  logic [(8 << LOG_BLOCK_DATA_BYTES)-1:0] m_r_data,
    input  logic [TID_WIDTH-1:0]                   m_r_id,
    output logic                                   busy,
    output logic                                   done,
    output logic [CNT_WIDTH+BURST_LEN_WIDTH-1:0]   beatCnt,
    output logic [(8 << LOG_BLOCK_DATA_BYTES)-1:0] lastData,
    output logic [1:0]                             errorCode
);

    localparam int DATA_WIDTH = 8 << LOG_BLOCK_DATA_BYTES;
    localparam int OUT_W      = LOG_MAX_OUTSTANDING + 1;
    localparam int BEAT_W     = CNT_WIDTH + BURST_LEN_WIDTH;
    localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(1 << LOG_MAX_OUTSTANDING);

    rdgen_state_e               state_q, state_d;
    rdgen_err_e                 err_q, err_d, new_err;
    logic [ADDR_BITS-1:0]       addr_q, addr_d;
    logic [ADDR_BITS-1:0]       stride_q, stride_d;
    logic [CNT_WIDTH-1:0]       count_q, count_d;
    logic [CNT_WIDTH-1:0]       issued_q, issued_d;
    logic [BURST_LEN_WIDTH-1:0] len_q, len_d;
    logic [BURST_LEN_WIDTH-1:0] bidx_q, bidx_d;
    logic [TID_WIDTH-1:0]       id_q, id_d;
    logic [OUT_W-1:0]           outst_q, outst_d;
    logic                       ar_valid_q, ar_valid_d;
    logic                       done_q, done_d;
    logic [BEAT_W-1:0]          beat_cnt_q, beat_cnt_d;
    logic [DATA_WIDTH-1:0]      last_data_q, last_data_d;

    logic ar_hs;
    logic r_acc;
    logic r_ready;
    logic last_dec;
    logic checking;

    assign r_ready  = (state_q != IDLE);
    assign ar_hs    = ar_valid_q & m_ar_ready;
    assign r_acc    = m_r_valid & r_ready;
    // An unsolicited last beat must not underflow the outstanding count.
    assign last_dec = r_acc & m_r_last & (outst_q != '0);
    assign checking = (state_q == RUN) || (state_q == DRAIN);

    // Classify the beat being accepted this cycle; unsolicited outranks id, id outranks last.
    always_comb begin
        new_err = ERR_NONE;
        if (r_acc && checking) begin
            if (outst_q == '0) begin
                new_err = ERR_UNSOL;
            end else if (m_r_id != id_q) begin
                new_err = ERR_ID;
            end else if (m_r_last != (bidx_q == len_q)) begin
                new_err = ERR_LAST;
            end
        end
    end

    // Next-state, counters, address walk and launch of a new run.
    always_comb begin
        state_d     = state_q;
        err_d       = err_q;
        addr_d      = addr_q;
        stride_d    = stride_q;
        count_d     = count_q;
        issued_d    = issued_q;
        len_d       = len_q;
        bidx_d      = bidx_q;
        id_d        = id_q;
        outst_d     = outst_q;
        done_d      = 1'b0;
        beat_cnt_d  = beat_cnt_q;
        last_data_d = last_data_q;

        if (r_acc) begin
            if (beat_cnt_q != '1) begin
                beat_cnt_d = beat_cnt_q + 1'b1;
            end
            last_data_d = m_r_data;
            bidx_d      = m_r_last ? '0 : bidx_q + 1'b1;
        end

        case ({ar_hs, last_dec})
            2'b10:   outst_d = outst_q + 1'b1;
            2'b01:   outst_d = outst_q - 1'b1;
            default: outst_d = outst_q;
        endcase

        if (ar_hs) begin
            issued_d = issued_q + 1'b1;
            addr_d   = addr_q + stride_q;
        end

        case (state_q)
            RUN, DRAIN: begin
                if (new_err != ERR_NONE) begin
                    err_d   = new_err;
                    state_d = ERR;
                end else if (issued_d == count_q) begin
                    if (outst_d == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            default: begin
                if (start) begin
                    addr_d     = cfg_base;
                    stride_d   = cfg_stride;
                    count_d    = cfg_count;
                    len_d      = cfg_len;
                    id_d       = cfg_id;
                    issued_d   = '0;
                    beat_cnt_d = '0;
                    err_d      = ERR_NONE;
                    if (cfg_count == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
        endcase

        // Valid is registered from next-cycle values so it drops right after the filling handshake.
        ar_valid_d = (state_d == RUN) && (issued_d < count_d) && (outst_d < MAX_OUT);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= IDLE;
            err_q       <= ERR_NONE;
            addr_q      <= '0;
            stride_q    <= '0;
            count_q     <= '0;
            issued_q    <= '0;
            len_q       <= '0;
            bidx_q      <= '0;
            id_q        <= '0;
            outst_q     <= '0;
            ar_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            beat_cnt_q  <= '0;
            last_data_q <= '0;
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            addr_q      <= addr_d;
            stride_q    <= stride_d;
            count_q     <= count_d;
            issued_q    <= issued_d;
            len_q       <= len_d;
            bidx_q      <= bidx_d;
            id_q        <= id_d;
            outst_q     <= outst_d;
            ar_valid_q  <= ar_valid_d;
            done_q      <= done_d;
            beat_cnt_q  <= beat_cnt_d;
            last_data_q <= last_data_d;
        end
    end

    assign m_ar_valid = ar_valid_q;
    assign m_ar_addr  = addr_q;
    assign m_ar_len   = len_q;
    assign m_ar_id    = id_q;
    assign m_r_ready  = r_ready;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign beatCnt    = beat_cnt_q;
    assign lastData   = last_data_q;
    assign errorCode  = err_q;

endmodule

// File: tb/tb_axi_stride_rd_gen.sv
// Bench for axi_stride_rd_gen: directed scenarios plus randomized runs, all
// compared cycle by cycle against a transaction-level model of the generator.
module tb_axi_stride_rd_gen;

    logic        clk = 1'b0;
    logic        resetN;
    logic        start;
    logic [63:0] cfg_base, cfg_stride;
    logic [15:0] cfg_count;
    logic [7:0]  cfg_len;
    logic [3:0]  cfg_id;
    logic        m_ar_valid, m_ar_ready;
    logic [63:0] m_ar_addr;
    logic [7:0]  m_ar_len;
    logic [3:0]  m_ar_id;
    logic        m_r_valid, m_r_ready, m_r_last;
    logic [63:0] m_r_data;
    logic [3:0]  m_r_id;
    logic        busy, done;
    logic [23:0] beatCnt;
    logic [63:0] lastData;
    logic [1:0]  errorCode;

    int checks = 0;
    int errors = 0;

    axi_stride_rd_gen dut (
        .clk(clk), .resetN(resetN), .start(start),
        .cfg_base(cfg_base), .cfg_stride(cfg_stride), .cfg_count(cfg_count),
        .cfg_len(cfg_len), .cfg_id(cfg_id),
        .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr),
        .m_ar_len(m_ar_len), .m_ar_id(m_ar_id),
        .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_last(m_r_last),
        .m_r_data(m_r_data), .m_r_id(m_r_id),
        .busy(busy), .done(done), .beatCnt(beatCnt), .lastData(lastData),
        .errorCode(errorCode)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: 0 idle, 1 active (issuing or draining), 2 error.
    int          md_state = 0;
    logic [63:0] md_base = 0, md_stride = 0;
    int          md_count = 0, md_issued = 0, md_outst = 0, md_bidx = 0, md_err = 0;
    int          md_len = 0, md_id = 0;
    logic [23:0] md_beats = 0;
    logic [63:0] md_last = 0;
    bit          md_done = 0, md_vld = 0;
    bit          md_hs, md_acc;
    int          md_e;

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            md_state = 0; md_base = 0; md_stride = 0; md_count = 0; md_issued = 0;
            md_outst = 0; md_bidx = 0; md_err = 0; md_len = 0; md_id = 0;
            md_beats = 0; md_last = 0; md_done = 0; md_vld = 0;
        end else begin
            md_hs   = md_vld && m_ar_ready;
            md_acc  = m_r_valid && (md_state != 0);
            md_done = 0;
            md_e    = 0;
            if (md_acc) begin
                if (md_state == 1) begin
                    if (md_outst == 0)                           md_e = 3;
                    else if (int'(m_r_id) != md_id)              md_e = 2;
                    else if (m_r_last != (md_bidx == md_len))    md_e = 1;
                end
                if (md_beats != 24'hFFFFFF) md_beats = md_beats + 1;
                md_last = m_r_data;
                if (m_r_last) begin
                    md_bidx = 0;
                    if (md_outst > 0) md_outst--;
                end else begin
                    md_bidx++;
                end
            end
            if (md_hs) begin
                md_issued++;
                md_outst++;
            end
            if (md_state == 1) begin
                if (md_e != 0) begin
                    md_err   = md_e;
                    md_state = 2;
                end else if (md_issued == md_count && md_outst == 0) begin
                    md_state = 0;
                    md_done  = 1;
                end
            end else if (start) begin
                md_base = cfg_base; md_stride = cfg_stride; md_count = int'(cfg_count);
                md_len = int'(cfg_len); md_id = int'(cfg_id);
                md_issued = 0; md_beats = 0; md_err = 0;
                if (cfg_count == 0) begin
                    md_state = 0;
                    md_done  = 1;
                end else begin
                    md_state = 1;
                end
            end
            md_vld = (md_state == 1) && (md_issued < md_count) && (md_outst < 4);
        end
    end

    // Per-cycle comparison, away from the active edge.
    int done_cnt = 0;
    always @(negedge clk) begin
        chk("ar_valid", m_ar_valid, md_vld);
        if (md_vld) begin
            chk("ar_addr", m_ar_addr, md_base + 64'(md_issued) * md_stride);
            chk("ar_len", m_ar_len, 64'(md_len));
            chk("ar_id", m_ar_id, 64'(md_id));
        end
        chk("r_ready", m_r_ready, md_state != 0);
        chk("busy", busy, md_state != 0);
        chk("done", done, md_done);
        chk("beatCnt", beatCnt, md_beats);
        chk("lastData", lastData, md_last);
        chk("errorCode", errorCode, 64'(md_err));
        if (done) done_cnt++;
    end

    // Memory-side responder and stimulus driver.
    int          pend[$];
    logic [63:0] ar_log[$];
    int          rb = 0;
    int          hs_cnt = 0;
    int          ar_pct = 100, r_pct = 100;
    bit          rsp_en = 1, early_last = 0;

    task automatic tick();
        @(posedge clk);
        if (m_ar_valid && m_ar_ready) begin
            pend.push_back(int'(m_ar_len));
            ar_log.push_back(m_ar_addr);
            hs_cnt++;
        end
        if (m_r_valid && m_r_ready) begin
            if (m_r_last) begin
                if (pend.size() > 0) void'(pend.pop_front());
                rb = 0;
            end else begin
                rb++;
            end
        end
        #1;
        start      = 1'b0;
        m_ar_ready = ($urandom_range(99) < ar_pct);
        if (rsp_en && pend.size() > 0 && $urandom_range(99) < r_pct) begin
            m_r_valid = 1'b1;
            m_r_id    = cfg_id;
            m_r_last  = (rb == pend[0]) || (early_last && rb == 2);
            m_r_data  = {$urandom, $urandom};
        end else begin
            m_r_valid = 1'b0;
            m_r_last  = 1'b0;
        end
    endtask

    task automatic launch(input logic [63:0] b, input logic [63:0] s, input int n,
                          input int l, input int id);
        cfg_base = b; cfg_stride = s; cfg_count = 16'(n); cfg_len = 8'(l); cfg_id = 4'(id);
        start = 1'b1;
        tick();
    endtask

    task automatic wait_done(input int budget, input string name);
        int d0 = done_cnt;
        int n  = 0;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (done_cnt == d0) begin
            errors++;
            $display("FAIL %s: no done within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_err(input int budget, input string name);
        int n = 0;
        while (errorCode == 2'd0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (errorCode == 2'd0) begin
            errors++;
            $display("FAIL %s: no error within %0d cycles", name, budget);
        end
    endtask

    initial begin
        int d0, h0, n;
        resetN = 1'b0; start = 1'b0;
        cfg_base = 0; cfg_stride = 0; cfg_count = 0; cfg_len = 0; cfg_id = 0;
        m_ar_ready = 1'b0; m_r_valid = 1'b0; m_r_last = 1'b0; m_r_data = 0; m_r_id = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ar_valid", m_ar_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_beatCnt", beatCnt, 0);
        chk("rst_errorCode", errorCode, 0);
        resetN = 1'b1;
        tick();

        // Basic stride walk, single-beat bursts.
        ar_log.delete();
        launch(64'h100, 64'h40, 4, 0, 5);
        chk("start_to_arvalid", m_ar_valid, 1);
        wait_done(200, "t1_done");
        chk("t1_ar_count", ar_log.size(), 4);
        if (ar_log.size() == 4) begin
            chk("t1_addr0", ar_log[0], 64'h100);
            chk("t1_addr1", ar_log[1], 64'h140);
            chk("t1_addr2", ar_log[2], 64'h180);
            chk("t1_addr3", ar_log[3], 64'h1C0);
        end
        chk("t1_beatCnt", beatCnt, 4);

        // Outstanding limit with R held off.
        rsp_en = 0;
        h0 = hs_cnt;
        launch(64'h1000, 64'h80, 6, 1, 2);
        repeat (20) tick();
        chk("t2_hs_at_limit", hs_cnt - h0, 4);
        chk("t2_ar_valid_low", m_ar_valid, 0);
        rsp_en = 1;
        n = 0;
        while (hs_cnt - h0 < 5 && n < 50) begin
            tick();
            n++;
        end
        chk("t2_fifth_ar", hs_cnt - h0 >= 5, 1);
        wait_done(500, "t2_done");
        chk("t2_beatCnt", beatCnt, 12);

        // Negative stride wraps below zero.
        ar_log.delete();
        launch(64'h8, 64'hFFFF_FFFF_FFFF_FFF0, 3, 0, 1);
        wait_done(200, "t3_done");
        chk("t3_ar_count", ar_log.size(), 3);
        if (ar_log.size() >= 2) chk("t3_wrap_addr", ar_log[1], 64'hFFFF_FFFF_FFFF_FFF8);
        chk("t3_no_error", errorCode, 0);

        // Early last -> error 1, no done, cleared by restart.
        early_last = 1;
        d0 = done_cnt;
        launch(64'h2000, 64'h100, 3, 3, 4);
        wait_err(200, "t4_err");
        chk("t4_errorCode", errorCode, 1);
        chk("t4_busy_in_err", busy, 1);
        repeat (30) tick();
        early_last = 0;
        repeat (30) tick();
        chk("t4_no_done", done_cnt, d0);
        chk("t4_err_sticky", errorCode, 1);
        launch(64'h3000, 64'h40, 2, 0, 4);
        chk("t4_err_cleared", errorCode, 0);
        wait_done(200, "t4_restart_done");

        // Unsolicited beat with a wrong id -> unsolicited wins.
        rsp_en = 0;
        ar_pct = 0;
        launch(64'h4000, 64'h40, 2, 0, 6);
        tick();
        m_r_valid = 1'b1; m_r_id = 4'(6 ^ 1); m_r_last = 1'b1; m_r_data = 64'hDEAD_BEEF_0000_0001;
        tick();
        tick();
        chk("t5_errorCode", errorCode, 3);
        chk("t5_lastData", lastData, 64'hDEAD_BEEF_0000_0001);

        // Reset mid-burst with two bursts open.
        ar_pct = 100;
        h0 = hs_cnt;
        launch(64'h5000, 64'h40, 4, 1, 3);
        n = 0;
        while (hs_cnt - h0 < 2 && n < 50) begin
            tick();
            n++;
        end
        chk("t6_two_open", hs_cnt - h0, 2);
        resetN = 1'b0;
        #1;
        chk("t6_rst_ar_valid", m_ar_valid, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_errorCode", errorCode, 0);
        pend.delete();
        rb = 0;
        m_r_valid = 1'b0;
        repeat (2) tick();
        resetN = 1'b1;
        rsp_en = 1;
        tick();
        launch(64'h6000, 64'h40, 3, 1, 3);
        wait_done(200, "t6_restart_done");
        chk("t6_restart_err", errorCode, 0);
        chk("t6_restart_beats", beatCnt, 6);

        // Zero-count start.
        h0 = hs_cnt;
        launch(64'h7000, 64'h40, 0, 0, 1);
        chk("t6_zero_done", done, 1);
        chk("t6_zero_busy", busy, 0);
        chk("t6_zero_ar_valid", m_ar_valid, 0);
        tick();
        chk("t6_zero_done_pulse", done, 0);
        chk("t6_zero_no_ar", hs_cnt - h0, 0);

        // Randomized runs.
        for (int it = 0; it < 25; it++) begin
            ar_pct = $urandom_range(100, 30);
            r_pct  = $urandom_range(100, 30);
            launch({$urandom, $urandom}, {$urandom, $urandom},
                   $urandom_range(8, 1), $urandom_range(3, 0), $urandom_range(15, 0));
            wait_done(3000, "rand_done");
            repeat ($urandom_range(3, 0)) tick();
        end

        repeat (5) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
